// File: rtl/data_cache.sv
// Commit-side data memory: in-order store write buffer draining into a word array,
// with tagged one-cycle loads. Define DCACHE_FORWARD_EN for store-to-load forwarding.
module data_cache #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_BITS  = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int RB_INDEX   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_mem,
  input  logic [WORD_SIZE-1:0] ws_mem,
  input  logic [WORD_SIZE-1:0] wd_mem,
  output logic                 wbuf_full,
  output logic                 wbuf_empty,
  output logic                 wr_overflow,
  input  logic                 rd_req,
  input  logic [WORD_SIZE-1:0] rd_addr,
  input  logic [RB_INDEX-1:0]  rd_tag,
  output logic                 rd_ready,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [RB_INDEX-1:0]  rd_tag_out
);
  localparam int PW = $clog2(WBUF_DEPTH);

  logic [ADDR_BITS-1:0] wb_addr_q [WBUF_DEPTH];
  logic [WORD_SIZE-1:0] wb_data_q [WBUF_DEPTH];
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  logic [PW-1:0]         head_q, tail_q;
  logic [PW:0]           count_q, count_d;
  logic                  ovf_q, vld_q;
  logic [WORD_SIZE-1:0]  data_q, rd_data_d;
  logic [RB_INDEX-1:0]   tag_q;

  logic [ADDR_BITS-1:0]  ridx, widx;
  logic                  hit, rd_acc, drain, enq;
  logic [PW-1:0]         slot;
`ifdef DCACHE_FORWARD_EN
  logic [WORD_SIZE-1:0]  fwd_data;
`endif

  logic unused_hi;
  assign unused_hi = ^{ws_mem[WORD_SIZE-1:ADDR_BITS], rd_addr[WORD_SIZE-1:ADDR_BITS]};

  assign ridx       = rd_addr[ADDR_BITS-1:0];
  assign widx       = ws_mem[ADDR_BITS-1:0];
  assign wbuf_full  = (count_q == (PW+1)'(WBUF_DEPTH));
  assign wbuf_empty = (count_q == '0);

  // Scan oldest to youngest so the last match wins (youngest store).
  always_comb begin
    hit  = 1'b0;
    slot = '0;
`ifdef DCACHE_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((PW+1)'(k) < count_q && wb_addr_q[slot] == ridx) begin
        hit = 1'b1;
`ifdef DCACHE_FORWARD_EN
        fwd_data = wb_data_q[slot];
`endif
      end
    end
  end

`ifdef DCACHE_FORWARD_EN
  assign rd_ready  = !wbuf_full;
  assign rd_data_d = hit ? fwd_data : mem[ridx];
`else
  // Without forwarding a load must wait until its address has drained.
  assign rd_ready  = !wbuf_full && !hit;
  assign rd_data_d = mem[ridx];
`endif

  // A full buffer blocks reads, so drain yields only to an accepted load.
  assign rd_acc = rd_req && rd_ready;
  assign drain  = !wbuf_empty && !rd_acc;
  assign enq    = we_mem && !wbuf_full;

  always_comb begin
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      count_q <= count_d;
      if (enq)   tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      if (we_mem && wbuf_full) ovf_q <= 1'b1;
      vld_q <= rd_acc;
      if (rd_acc) begin
        data_q <= rd_data_d;
        tag_q  <= rd_tag;
      end
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      wb_addr_q[tail_q] <= widx;
      wb_data_q[tail_q] <= wd_mem;
    end
    if (drain) mem[wb_addr_q[head_q]] <= wb_data_q[head_q];
  end

  assign wr_overflow = ovf_q;
  assign rd_valid    = vld_q;
  assign rd_data     = data_q;
  assign rd_tag_out  = tag_q;
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed table, hand sequences and a
// randomized run against a queue-based reference model.
module tb_data_cache;
`ifdef DCACHE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 0, reset = 0;
  logic        we_mem = 0, rd_req = 0;
  logic [31:0] ws_mem = 0, wd_mem = 0, rd_addr = 0;
  logic [3:0]  rd_tag = 0;
  logic        wbuf_full, wbuf_empty, wr_overflow, rd_ready, rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_tag_out;

  data_cache dut (
    .clk(clk), .reset(reset), .we_mem(we_mem), .ws_mem(ws_mem), .wd_mem(wd_mem),
    .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty), .wr_overflow(wr_overflow),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag_out(rd_tag_out)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending stores in order, plus the word array.
  typedef struct { logic [7:0] a; logic [31:0] d; } st_t;
  st_t         wq[$];
  logic [31:0] mm [256];
  bit          m_ovf = 0, m_vld = 0;
  logic [31:0] m_data = 0;
  logic [3:0]  m_tag = 0;

  task automatic model_reset();
    wq.delete();
    m_ovf = 0; m_vld = 0; m_data = 0; m_tag = 0;
  endtask

  // One clock: drive, compare at negedge, advance model, return at posedge+1.
  task automatic cyc(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                     input bit rq, input logic [7:0] ra, input logic [3:0] rt,
                     output bit acc);
    bit full, hit, rdy;
    logic [31:0] fd;
    we_mem = we; ws_mem = {24'($urandom), wa}; wd_mem = wd;
    rd_req = rq; rd_addr = {24'($urandom), ra}; rd_tag = rt;
    @(negedge clk);
    full = (wq.size() == DEPTH);
    hit = 0; fd = 0;
    foreach (wq[i]) if (wq[i].a == ra) begin hit = 1; fd = wq[i].d; end
    rdy = !full && (FWD || !hit);
    chk("wbuf_full", 32'(wbuf_full), 32'(full));
    chk("wbuf_empty", 32'(wbuf_empty), 32'(wq.size() == 0));
    chk("rd_ready", 32'(rd_ready), 32'(rdy));
    chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    if (m_vld) begin
      chk("rd_data", rd_data, m_data);
      chk("rd_tag_out", 32'(rd_tag_out), 32'(m_tag));
    end
    acc = rq && rdy;
    m_vld = acc;
    if (acc) begin
      m_data = (FWD && hit) ? fd : mm[ra];
      m_tag  = rt;
    end
    if (wq.size() > 0 && !acc) begin
      mm[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
    if (we && !full) wq.push_back('{wa, wd});
    if (we && full) m_ovf = 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, a);
  endtask

  // Hold a load until accepted, then return its response sampled after the edge.
  task automatic load_wait(input logic [7:0] ra, input logic [3:0] rt, output logic [31:0] d);
    bit a = 0;
    int n = 0;
    while (!a && n < 20) begin cyc(0, 0, 0, 1, ra, rt, a); n++; end
    chk("load_accept_timeout", 32'(a), 32'd1);
    d = rd_data;
    chk("load_resp_valid", 32'(rd_valid), 32'd1);
    chk("load_resp_tag", 32'(rd_tag_out), 32'(rt));
  endtask

  typedef struct {
    bit we; logic [7:0] wa; logic [31:0] wd;
    bit rq; logic [7:0] ra; logic [3:0] rt;
    bit e_rdy; bit e_emp; bit e_vld; logic [31:0] e_data; logic [3:0] e_tag;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [31:0] d;
    bit a;

    tbl[0] = '{1, 8'd5, 32'hA5A5_0001, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 8'd5, 4'd3, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'hA5A5_0001, 4'd3};
    tbl[5] = '{1, 8'd5, 32'h0000_BEEF, 1, 8'd5, 4'd5, 1, 1, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hA5A5_0001, 4'd5};
    tbl[7] = '{0, 0, 0, 1, 8'd5, 4'd6, 1, 1, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0000_BEEF, 4'd6};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 32'(wbuf_empty), 32'd1);
    chk("rst_full", 32'(wbuf_full), 32'd0);
    chk("rst_ovf", 32'(wr_overflow), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_tag", 32'(rd_tag_out), 32'd0);
    reset = 1;

    // Directed table: store/load with no contention, same-cycle store+load
    foreach (tbl[i]) begin
      we_mem = tbl[i].we; ws_mem = {24'hABCDEF, tbl[i].wa}; wd_mem = tbl[i].wd;
      rd_req = tbl[i].rq; rd_addr = {24'h123456, tbl[i].ra}; rd_tag = tbl[i].rt;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), 32'(rd_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_empty", i), 32'(wbuf_empty), 32'(tbl[i].e_emp));
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_tag", i), 32'(rd_tag_out), 32'(tbl[i].e_tag));
      end
      @(posedge clk); #1;
    end
    we_mem = 0; rd_req = 0;
    @(posedge clk); #1;

    // Model takes over: prefill every address used below
    model_reset();
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), $urandom, 0, 0, 0, a);
    for (int i = 20; i < 25; i++) cyc(1, 8'(i), 32'hDEAD_0000 + 32'(i), 0, 0, 0, a);
    cyc(1, 8'd200, 32'hC0DE_00C8, 0, 0, 0, a);
    cyc(1, 8'd9, 32'h0, 0, 0, 0, a);
    idle(3);

    // Two stores to one address, load right after: youngest data wins
    cyc(1, 8'd7, 32'h11, 0, 0, 0, a);
    cyc(1, 8'd7, 32'h22, 0, 0, 0, a);
    load_wait(8'd7, 4'd2, d);
    chk("fwd_youngest", d, 32'h22);
    idle(3);

    // Fill with loads held every cycle; fifth store hits a full buffer
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(20 + i), 32'h5500_0000 + 32'(i), 1, 8'd200, 4'(i), a);
      if (i == 4) chk("full_blocks_read", 32'(a), 32'd0);
    end
    chk("ovf_sticky", 32'(wr_overflow), 32'd1);
    idle(6);
    load_wait(8'd24, 4'd9, d);
    chk("dropped_store", d, 32'hDEAD_0018);
    load_wait(8'd23, 4'd8, d);
    chk("kept_store", d, 32'h5500_0003);

    // Pointer wrap: 10 stores interleaved with continuous loads
    begin
      logic [7:0] la = 8'($urandom_range(0, 9));
      int s = 0;
      for (int n = 0; n < 200 && (s < 10 || wq.size() > 0); n++) begin
        bit w = (s < 10);
        cyc(w, 8'(s), 32'h0C00_0000 + 32'(s), 1, la, 4'(n), a);
        if (w && !(wq.size() == 0 && 0)) s = s + ((!a || 1) ? 1 : 0);
        if (a) la = 8'($urandom_range(0, 9));
      end
      idle(12);
      chk("wrap_empty", 32'(wbuf_empty), 32'd1);
    end

    // Same-cycle store and load to addr 9: load sees the old value
    idle(4);
    cyc(1, 8'd9, 32'h99, 1, 8'd9, 4'd4, a);
    chk("same_cycle_acc", 32'(a), 32'd1);
    chk("same_cycle_old", rd_data, 32'h0);
    load_wait(8'd9, 4'd5, d);
    chk("next_cycle_new", d, 32'h99);

    // Randomized traffic
    begin
      logic [7:0] la = 0;
      logic [3:0] lt = 0;
      bit lq = 0;
      for (int n = 0; n < 400; n++) begin
        if (!lq) begin
          lq = ($urandom_range(0, 2) != 0);
          la = 8'($urandom_range(0, 15));
          lt = 4'($urandom);
        end
        cyc($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), $urandom, lq, la, lt, a);
        if (a) lq = 0;
      end
    end

    // Async reset with 3 entries buffered and a response pending
    idle(8);
    cyc(1, 8'd1, 32'hF1, 1, 8'd2, 4'd1, a);
    cyc(1, 8'd2, 32'hF2, 1, 8'd3, 4'd2, a);
    cyc(1, 8'd3, 32'hF3, 1, 8'd4, 4'd3, a);
    reset = 0;
    #1;
    chk("arst_empty", 32'(wbuf_empty), 32'd1);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_ovf", 32'(wr_overflow), 32'd0);
    chk("arst_data", rd_data, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1;
    idle(5);
    load_wait(8'd1, 4'd7, d);
    chk("arst_discarded", d, mm[1]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
